// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet receive constants, framer state encoding, CRC helpers
package eth_pkg;

  // Receive framer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  // Register value left after running data plus a correct FCS through the CRC
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Bit-reverse a 32-bit word; the LSB-first datapath needs the mirrored polynomial
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// rtl/eth_crc32_byte.sv - one-byte reflected CRC-32 next-state (combinational)
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [7:0]  data_in,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  // Eight LSB-first shift/XOR steps folded into one combinational update
  always_comb begin
    crc_out = crc_in ^ {24'h0, data_in};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// rtl/gmii_rx_framer.sv - GMII/MII receive framer; define GMII_RX_CRC_CHECK_EN for FCS checking
module gmii_rx_framer
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic       mii_select,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       error_bad_frame,
  output logic       error_bad_fcs
);

  localparam logic [2:0] LINE_DEPTH = 3'd5;

  rx_state_e       state_q, state_d;
  logic            mode_q, mode_d;          // 1: nibble (MII) mode for the current frame
  logic            phase_q, phase_d;        // 1: next nibble completes a byte
  logic [3:0]      nib_lo_q, nib_lo_d;
  logic [3:0]      prev_nib_q, prev_nib_d;
  logic [4:0][7:0] line_q, line_d;          // [0] newest byte, [4] oldest
  logic [2:0]      fill_q, fill_d;
  logic [15:0]     count_q, count_d;
  logic            er_seen_q, er_seen_d;
  logic [7:0]      tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            tuser_q, tuser_d;
  logic            bad_frame_q, bad_frame_d;
  logic            bad_fcs_q, bad_fcs_d;

  logic            byte_vld;
  logic [7:0]      byte_val;
  logic            enter_payload;
  logic            crc_bad;
  logic            is_short;
  logic            frame_bad;

  // Byte assembly: whole bytes in GMII mode, low-then-high nibble pairs in MII mode
  always_comb begin
    byte_val = gmii_rxd;
    byte_vld = gmii_rx_dv;
    if (mode_q) begin
      byte_val = {gmii_rxd[3:0], nib_lo_q};
      byte_vld = gmii_rx_dv && phase_q;
    end
  end

`ifdef GMII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_next;

  eth_crc32_byte u_crc (
    .data_in (byte_val),
    .crc_in  (crc_q),
    .crc_out (crc_next)
  );

  // Running CRC over every byte after the SFD, FCS included
  always_comb begin
    crc_d = crc_q;
    if (enter_payload) crc_d = CRC32_INIT;
    else if (state_q == ST_PAYLOAD && byte_vld) crc_d = crc_next;
  end

  // CRC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc_bad = (crc_q != CRC32_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  assign is_short  = ({16'h0, count_q} < MIN_FRAME_LEN);
  assign frame_bad = er_seen_q | (mode_q & phase_q) | is_short | crc_bad;

  // Next-state, delay line and output beat generation
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    phase_d       = phase_q;
    nib_lo_d      = nib_lo_q;
    prev_nib_d    = prev_nib_q;
    line_d        = line_q;
    fill_d        = fill_q;
    count_d       = count_q;
    er_seen_d     = er_seen_q;
    tdata_d       = tdata_q;
    tvalid_d      = 1'b0;
    tlast_d       = 1'b0;
    tuser_d       = 1'b0;
    bad_frame_d   = 1'b0;
    bad_fcs_d     = 1'b0;
    enter_payload = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mode_d     = mii_select;
        prev_nib_d = gmii_rxd[3:0];
        if (gmii_rx_dv) state_d = ST_PREAMBLE;
      end

      ST_PREAMBLE: begin
        prev_nib_d = gmii_rxd[3:0];
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
        end else if (gmii_rx_er) begin
          state_d = ST_DROP;
        end else if (mode_q) begin
          // Nibble alignment is fixed by the 0x5 -> 0xD pair of the SFD
          if (gmii_rxd[3:0] == ETH_SFD[7:4] && prev_nib_q == ETH_SFD[3:0]) enter_payload = 1'b1;
          else if (gmii_rxd[3:0] != ETH_PREAMBLE[3:0])                      state_d = ST_DROP;
        end else if (gmii_rxd == ETH_SFD) begin
          enter_payload = 1'b1;
        end else if (gmii_rxd != ETH_PREAMBLE) begin
          state_d = ST_DROP;
        end
      end

      ST_PAYLOAD: begin
        if (!gmii_rx_dv) begin
          // Close the frame; the four bytes still in stages 0-3 are the FCS
          state_d = ST_IDLE;
          if (fill_q == LINE_DEPTH) begin
            tvalid_d    = 1'b1;
            tlast_d     = 1'b1;
            tdata_d     = line_q[4];
            tuser_d     = frame_bad;
            bad_frame_d = frame_bad;
            bad_fcs_d   = crc_bad;
          end else begin
            bad_frame_d = 1'b1;
          end
        end else begin
          if (gmii_rx_er) er_seen_d = 1'b1;
          if (mode_q) begin
            phase_d = ~phase_q;
            if (!phase_q) nib_lo_d = gmii_rxd[3:0];
          end
          if (byte_vld) begin
            line_d = {line_q[3:0], byte_val};
            if (fill_q == LINE_DEPTH) begin
              tvalid_d = 1'b1;
              tdata_d  = line_q[4];
            end else begin
              fill_d = fill_q + 3'd1;
            end
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          end
        end
      end

      ST_DROP: begin
        if (!gmii_rx_dv) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (enter_payload) begin
      state_d   = ST_PAYLOAD;
      fill_d    = 3'd0;
      count_d   = 16'd0;
      er_seen_d = 1'b0;
      phase_d   = 1'b0;
    end
  end

  // State, delay line and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      phase_q     <= 1'b0;
      nib_lo_q    <= '0;
      prev_nib_q  <= '0;
      line_q      <= '0;
      fill_q      <= '0;
      count_q     <= '0;
      er_seen_q   <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      bad_frame_q <= 1'b0;
      bad_fcs_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      nib_lo_q    <= nib_lo_d;
      prev_nib_q  <= prev_nib_d;
      line_q      <= line_d;
      fill_q      <= fill_d;
      count_q     <= count_d;
      er_seen_q   <= er_seen_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      bad_frame_q <= bad_frame_d;
      bad_fcs_q   <= bad_fcs_d;
    end
  end

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tuser    = tuser_q;
  assign error_bad_frame = bad_frame_q;
  assign error_bad_fcs   = bad_fcs_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb/tb_gmii_rx_framer.sv - self-checking bench for gmii_rx_framer (honours GMII_RX_CRC_CHECK_EN)
module tb_gmii_rx_framer;

  localparam int MIN_LEN = 64;
`ifdef GMII_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  typedef struct {
    bit nib;
    int n_data;
    bit fcs;
    bit corrupt;
    int er_idx;
    bit extra;
    int exp_beats;
    int exp_tuser;
    int exp_bf;
    int exp_fcs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er, mii_select;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       error_bad_frame, error_bad_fcs;

  always #4 clk = ~clk;

  gmii_rx_framer #(.MIN_FRAME_LEN(MIN_LEN)) dut (
    .clk             (clk),
    .rst             (rst),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .mii_select      (mii_select),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .error_bad_frame (error_bad_frame),
    .error_bad_fcs   (error_bad_fcs)
  );

  int  errors = 0;
  int  checks = 0;
  bq_t got;
  int  tlast_cnt, tuser_last, tuser_stray, bf_cnt, fcs_cnt;

  // Output capture on the falling edge
  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      got.push_back(m_axis_tdata);
      if (m_axis_tlast) begin
        tlast_cnt  = tlast_cnt + 1;
        tuser_last = int'(m_axis_tuser);
      end else if (m_axis_tuser) begin
        tuser_stray = tuser_stray + 1;
      end
    end
    if (error_bad_frame) bf_cnt = bf_cnt + 1;
    if (error_bad_fcs)   fcs_cnt = fcs_cnt + 1;
  end

  task automatic clear();
    got.delete();
    tlast_cnt = 0; tuser_last = 0; tuser_stray = 0; bf_cnt = 0; fcs_cnt = 0;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ethernet FCS value of a byte sequence (transmitted LSB first)
  function automatic logic [31:0] crc32(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t make_body(input int n, input bit fcs, input bit corrupt, input bit rnd);
    bq_t b;
    logic [31:0] f;
    for (int i = 0; i < n; i++) b.push_back(rnd ? 8'($urandom) : 8'(i));
    if (fcs) begin
      f = crc32(b);
      for (int k = 0; k < 4; k++) b.push_back(f[8*k +: 8]);
      if (corrupt) b[b.size()-1] = b[b.size()-1] ^ 8'h01;
    end
    return b;
  endfunction

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    gmii_rx_dv = dv; gmii_rx_er = er; gmii_rxd = d;
    @(posedge clk); #1;
  endtask

  task automatic send_raw(input bit nib, input bq_t s, input int er_pos, input bit extra, input int gap);
    mii_select = nib;
    foreach (s[i]) begin
      if (nib) begin
        drive(1'b1, i == er_pos, {4'($urandom), s[i][3:0]});
        drive(1'b1, 1'b0,        {4'($urandom), s[i][7:4]});
      end else begin
        drive(1'b1, i == er_pos, s[i]);
      end
    end
    if (extra) drive(1'b1, 1'b0, 8'($urandom));
    for (int g = 0; g < gap; g++) drive(1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic send_frame(input bit nib, input int npre, input bq_t body, input int er_idx,
                            input bit extra, input int gap);
    bq_t s;
    for (int i = 0; i < npre; i++) s.push_back(8'h55);
    s.push_back(8'hD5);
    foreach (body[i]) s.push_back(body[i]);
    send_raw(nib, s, (er_idx < 0) ? -1 : er_idx + npre + 1, extra, gap);
  endtask

  task automatic chk_frame(input string tag, input bq_t exp, input int exp_tlast,
                           input int exp_tuser, input int exp_bf, input int exp_fcs);
    int mism;
    mism = 0;
    @(negedge clk); #1;
    chk({tag, " beats"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) if (got[i] !== exp[i]) mism++;
    chk({tag, " data_mismatches"}, mism, 0);
    chk({tag, " tlast"}, tlast_cnt, exp_tlast);
    chk({tag, " tuser"}, tuser_last, exp_tuser);
    chk({tag, " tuser_early"}, tuser_stray, 0);
    chk({tag, " bad_frame"}, bf_cnt, exp_bf);
    chk({tag, " bad_fcs"}, fcs_cnt, exp_fcs);
    clear();
  endtask

  // Reference: payload is everything after the SFD except the last four bytes
  task automatic model_check(input string tag, input bit nib, input bq_t body, input bit er_any,
                             input bit extra);
    bq_t exp;
    logic [31:0] fcs_field;
    bit fcs_bad, bad;
    int total;
    total = body.size();
    for (int i = 0; i + 4 < total; i++) exp.push_back(body[i]);
    fcs_bad = 1'b1;
    if (total > 4) begin
      fcs_field = {body[total-1], body[total-2], body[total-3], body[total-4]};
      fcs_bad   = (fcs_field != crc32(exp));
    end
    bad = er_any || (nib && extra) || (total < MIN_LEN) || (CRC_ON && fcs_bad);
    if (total > 4) chk_frame(tag, exp, 1, int'(bad), int'(bad), int'(CRC_ON && fcs_bad));
    else           chk_frame(tag, exp, 0, 0, 1, 0);
  endtask

  vec_t vecs[9];
  bq_t  body, seq, exp;
  bit   nib, fcs, cor, extra;
  int   er_idx;

  initial begin
    vecs[0] = '{0, 60, 1, 0, -1, 0, 60, 0, 0, 0};
    vecs[1] = '{0, 60, 1, 1, -1, 0, 60, int'(CRC_ON), int'(CRC_ON), int'(CRC_ON)};
    vecs[2] = '{1, 60, 1, 0, -1, 0, 60, 0, 0, 0};
    vecs[3] = '{1, 60, 1, 0, -1, 1, 60, 1, 1, 0};
    vecs[4] = '{0, 60, 1, 0, 10, 0, 60, 1, 1, 0};
    vecs[5] = '{0,  3, 0, 0, -1, 0,  0, 0, 1, 0};
    vecs[6] = '{0, 36, 1, 0, -1, 0, 36, 1, 1, 0};
    vecs[7] = '{1, 60, 1, 0, 25, 0, 60, 1, 1, 0};
    vecs[8] = '{0, 59, 1, 0, -1, 0, 59, 1, 1, 0};

    rst = 1'b1; gmii_rxd = '0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; mii_select = 1'b0;
    clear();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                          error_bad_frame, error_bad_fcs}, 0);
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 1'b1, 8'hFF);   // er without dv must be ignored in IDLE
    drive(1'b0, 1'b0, 8'h00);
    chk_frame("idle_er", exp, 0, 0, 0, 0);

    // Table-driven directed frames, sequential payload 0..n-1
    for (int v = 0; v < 9; v++) begin
      body = make_body(vecs[v].n_data, vecs[v].fcs, vecs[v].corrupt, 1'b0);
      send_frame(vecs[v].nib, 7, body, vecs[v].er_idx, vecs[v].extra, 3);
      exp.delete();
      for (int i = 0; i < vecs[v].exp_beats; i++) exp.push_back(8'(i));
      chk_frame($sformatf("vec%0d", v), exp, (vecs[v].exp_beats > 0) ? 1 : 0,
                vecs[v].exp_tuser, vecs[v].exp_bf, vecs[v].exp_fcs);
    end

    // Reset at payload byte 20: 15 beats already out, no tlast, no error pulse
    body = make_body(60, 1'b1, 1'b0, 1'b0);
    mii_select = 1'b0;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, body[i]);
    @(negedge clk); #1 rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("mid_reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                              error_bad_frame, error_bad_fcs}, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    exp.delete();
    for (int i = 0; i < 15; i++) exp.push_back(8'(i));
    chk_frame("abort", exp, 0, 0, 0, 0);
    send_frame(1'b0, 7, body, -1, 1'b0, 2);
    model_check("after_reset", 1'b0, body, 1'b0, 1'b0);

    // Bad preamble byte drops the frame; next frame after a one-cycle gap is intact
    seq = '{8'h55, 8'h55, 8'h57, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
    foreach (body[i]) seq.push_back(body[i]);
    send_raw(1'b0, seq, -1, 1'b0, 1);
    send_frame(1'b0, 7, body, -1, 1'b0, 3);
    model_check("after_drop", 1'b0, body, 1'b0, 1'b0);

    // Randomized frames against the reference model, gaps down to one cycle
    for (int f = 0; f < 40; f++) begin
      nib    = 1'($urandom);
      fcs    = ($urandom % 8) != 0;
      cor    = ($urandom % 4) == 0;
      body   = make_body($urandom_range(0, 75), fcs, cor, 1'b1);
      er_idx = (body.size() > 0 && ($urandom % 6) == 0) ? int'($urandom_range(0, body.size() - 1)) : -1;
      extra  = nib && (($urandom % 4) == 0);
      send_frame(nib, $urandom_range(1, 7), body, er_idx, extra, $urandom_range(1, 3));
      model_check($sformatf("rnd%0d", f), nib, body, er_idx >= 0, extra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
